// File: rtl/bk_add_pkg.sv
// Shared types and elaboration helpers for the pipelined Brent-Kung adder.
package bk_add_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int up_levels(input int width);
    return $clog2(width);
  endfunction

  function automatic int down_levels(input int width);
    return $clog2(width) - 1;
  endfunction

  // Number of register stages actually built; out-of-range depths are clamped.
  function automatic int stage_count(input int latency);
    return (latency < 1) ? 1 : ((latency > 3) ? 3 : latency);
  endfunction

  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/bk_add_pipe_if.sv
// Operand/result handshake bundle for bk_add_pipe.
// BK_ADD_OVF_EN adds the out_ovf signal.
interface bk_add_pipe_if #(
    parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
`ifdef BK_ADD_OVF_EN
  logic             out_ovf;

  modport master (output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                  input  in_ready, out_valid, out_sum, out_ovf);
  modport slave  (input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                  output in_ready, out_valid, out_sum, out_ovf);
`else
  modport master (output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                  input  in_ready, out_valid, out_sum);
  modport slave  (input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                  output in_ready, out_valid, out_sum);
`endif
endinterface

// File: rtl/bk_prefix_level.sv
// One combinational Brent-Kung prefix level; DOWN selects the down-sweep node pattern.
module bk_prefix_level
  import bk_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEVEL = 0,
  parameter bit DOWN  = 1'b0
) (
  input  pg_t [WIDTH-1:0] prv,
  output pg_t [WIDTH-1:0] nxt
);

  localparam int SPAN = 1 << LEVEL;
  localparam int STEP = 2 * SPAN;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // Up-sweep closes blocks at i = k*STEP-1; down-sweep fills the midpoints left open.
    localparam bit NODE = DOWN ? ((((i + 1) % STEP) == SPAN) && (i >= STEP))
                               : (((i + 1) % STEP) == 0);
    if (NODE) begin : g_node
      assign nxt[i] = pg_combine(prv[i], prv[i-SPAN]);
    end else begin : g_pass
      assign nxt[i] = prv[i];
    end
  end

endmodule

// File: rtl/bk_add_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready on both sides.
// Define BK_ADD_OVF_EN to add the signed-overflow output.
module bk_add_pipe
  import bk_add_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input logic          clk,
  input logic          rst_n,
  bk_add_pipe_if.slave bus
);

  localparam int UPL    = up_levels(WIDTH);
  localparam int DNL    = down_levels(WIDTH);
  localparam int STAGES = stage_count(LATENCY);
  localparam bit HAS_P0 = (STAGES >= 3);
  localparam bit HAS_P1 = (STAGES >= 2);

  logic             vld_p0, vld_p1, vld_p2;
  logic             rdy_p0, rdy_p1, rdy_p2;
  logic             cin_eff, cin_p0, cin_p1;
  logic [WIDTH-1:0] b_eff, prop_p0, prop_p1, carry, unused_grp_p;
  logic [WIDTH:0]   sum_nxt, sum_p2;
  pg_t  [WIDTH-1:0] gen_pg, pg_p0, up_pg, pg_p1, dn_pg;

  // P1: generate/propagate; carry-in folds into bit 0 so the prefix yields carries directly
  assign b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign cin_eff = bus.in_sub | bus.in_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pg
    assign gen_pg[i].p = bus.in_a[i] ^ b_eff[i];
    if (i == 0) begin : g_lsb
      assign gen_pg[i].g = (bus.in_a[i] & b_eff[i]) | ((bus.in_a[i] ^ b_eff[i]) & cin_eff);
    end else begin : g_bit
      assign gen_pg[i].g = bus.in_a[i] & b_eff[i];
    end
    assign prop_p0[i] = pg_p0[i].p;
  end

  if (HAS_P0) begin : g_p0
    assign rdy_p0 = ~vld_p0 | rdy_p1;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p0 <= 1'b0;
        pg_p0  <= '0;
        cin_p0 <= 1'b0;
      end else if (rdy_p0) begin
        vld_p0 <= bus.in_valid;
        if (bus.in_valid) begin
          pg_p0  <= gen_pg;
          cin_p0 <= cin_eff;
        end
      end
    end
  end else begin : g_p0_thru
    assign rdy_p0 = rdy_p1;
    assign vld_p0 = bus.in_valid;
    assign pg_p0  = gen_pg;
    assign cin_p0 = cin_eff;
  end

  // P2: up-sweep
  for (genvar l = 0; l < UPL; l++) begin : g_up
    pg_t [WIDTH-1:0] prv, nxt;
    if (l == 0) begin : g_src
      assign prv = pg_p0;
    end else begin : g_src
      assign prv = g_up[l-1].nxt;
    end
    bk_prefix_level #(.WIDTH(WIDTH), .LEVEL(l), .DOWN(1'b0)) u_level (.prv(prv), .nxt(nxt));
  end
  assign up_pg = g_up[UPL-1].nxt;

  if (HAS_P1) begin : g_p1
    assign rdy_p1 = ~vld_p1 | rdy_p2;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p1  <= 1'b0;
        pg_p1   <= '0;
        prop_p1 <= '0;
        cin_p1  <= 1'b0;
      end else if (rdy_p1) begin
        vld_p1 <= vld_p0;
        if (vld_p0) begin
          pg_p1   <= up_pg;
          prop_p1 <= prop_p0;
          cin_p1  <= cin_p0;
        end
      end
    end
  end else begin : g_p1_thru
    assign rdy_p1  = rdy_p2;
    assign vld_p1  = vld_p0;
    assign pg_p1   = up_pg;
    assign prop_p1 = prop_p0;
    assign cin_p1  = cin_p0;
  end

  // P3: down-sweep, then sum = p ^ carry-into-bit
  for (genvar k = 0; k < DNL; k++) begin : g_dn
    pg_t [WIDTH-1:0] prv, nxt;
    if (k == 0) begin : g_src
      assign prv = pg_p1;
    end else begin : g_src
      assign prv = g_dn[k-1].nxt;
    end
    bk_prefix_level #(.WIDTH(WIDTH), .LEVEL(UPL - 2 - k), .DOWN(1'b1)) u_level (.prv(prv), .nxt(nxt));
  end
  assign dn_pg = g_dn[DNL-1].nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign carry[i]        = dn_pg[i].g;
    assign unused_grp_p[i] = dn_pg[i].p;
  end
  assign sum_nxt = {carry[WIDTH-1], prop_p1 ^ {carry[WIDTH-2:0], cin_p1}};

  assign rdy_p2 = ~vld_p2 | bus.out_ready;

`ifdef BK_ADD_OVF_EN
  logic ovf_p2;
  // Signed overflow: carry into the MSB differs from carry out of it.
  wire  ovf_nxt = carry[WIDTH-1] ^ carry[WIDTH-2];
`endif

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      sum_p2 <= '0;
`ifdef BK_ADD_OVF_EN
      ovf_p2 <= 1'b0;
`endif
    end else if (rdy_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sum_p2 <= sum_nxt;
`ifdef BK_ADD_OVF_EN
        ovf_p2 <= ovf_nxt;
`endif
      end
    end
  end

  assign bus.in_ready  = rdy_p0;
  assign bus.out_valid = vld_p2;
  assign bus.out_sum   = sum_p2;
`ifdef BK_ADD_OVF_EN
  assign bus.out_ovf   = ovf_p2;
`endif

endmodule

// File: tb/tb_bk_add_pipe.sv
// Bench for bk_add_pipe at WIDTH=32, LATENCY 1..3 side by side on shared stimulus.
// Overflow checks are enabled when BK_ADD_OVF_EN is defined.
module tb_bk_add_pipe;

  localparam int W = 32;

  typedef struct {
    logic [W:0] sum;
    logic       ovf;
    int         acc;
    logic       lit_on;
    logic [W:0] lit;
    logic       lit_ovf;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic         lit_on = 1'b0, lit_ovf = 1'b0;
  logic [W:0]   lit = '0;
  int           lit_lat = 2;

  logic         ov [1:3];
  logic         ir [1:3];
  logic         oo [1:3];
  logic [W:0]   os [1:3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  beat_t q [1:3][$];

  for (genvar L = 1; L <= 3; L++) begin : g_lat
    bk_add_pipe_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in_a      = a;
    assign bus.in_b      = b;
    assign bus.in_cin    = cin;
    assign bus.in_sub    = sub;
    assign bus.out_ready = out_ready;
    bk_add_pipe #(.WIDTH(W), .LATENCY(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign ov[L] = bus.out_valid;
    assign ir[L] = bus.in_ready;
    assign os[L] = bus.out_sum;
`ifdef BK_ADD_OVF_EN
    assign oo[L] = bus.out_ovf;
`else
    assign oo[L] = 1'b0;
`endif
  end

  // Reference: plain modular arithmetic and signed range test.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, y, input logic c, s);
    logic [W-1:0] yb;
    yb = s ? ~y : y;
    return {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, (s | c)};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, y, input logic c, s);
    longint v;
    logic [W-1:0] yb;
    yb = s ? ~y : y;
    v = longint'($signed(x)) + longint'($signed(yb)) + longint'(s | c);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  function automatic logic [W:0] z(input logic x);
    return {{W{1'b0}}, x};
  endfunction

  task automatic chk(input string name, input int L, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lat=%0d t=%0t actual=%h required=%h", name, L, $time, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic  exp_ir, exp_ov;
    beat_t nb;
    for (int L = 1; L <= 3; L++) begin
      if (!rst_n) begin
        q[L].delete();
        chk("rst_valid", L, z(ov[L]), '0);
        chk("rst_sum", L, os[L], '0);
`ifdef BK_ADD_OVF_EN
        chk("rst_ovf", L, z(oo[L]), '0);
`endif
      end else begin
        exp_ir = (q[L].size() < L) || out_ready;
        chk("in_ready", L, z(ir[L]), z(exp_ir));
        exp_ov = 1'b0;
        if (q[L].size() > 0) exp_ov = (cyc >= q[L][0].acc + L - 1);
        chk("out_valid", L, z(ov[L]), z(exp_ov));
        if (ov[L] && q[L].size() > 0) begin
          chk("sum", L, os[L], q[L][0].sum);
`ifdef BK_ADD_OVF_EN
          chk("ovf", L, z(oo[L]), z(q[L][0].ovf));
`endif
          if (q[L][0].lit_on) begin
            chk("lit_sum", L, os[L], q[L][0].lit);
`ifdef BK_ADD_OVF_EN
            chk("lit_ovf", L, z(oo[L]), z(q[L][0].lit_ovf));
`endif
          end
          if (out_ready) void'(q[L].pop_front());
        end
        if (in_valid && ir[L]) begin
          nb.sum     = ref_sum(a, b, cin, sub);
          nb.ovf     = ref_ovf(a, b, cin, sub);
          nb.acc     = cyc + 1;
          nb.lit_on  = lit_on && (L == lit_lat);
          nb.lit     = lit;
          nb.lit_ovf = lit_ovf;
          q[L].push_back(nb);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until the lit_lat instance takes it.
  task automatic send(input logic [W-1:0] ta, tb_v, input logic tc, ts,
                      input logic tl_on, input logic [W:0] tl, input logic tlo);
    int   n;
    logic took;
    a = ta; b = tb_v; cin = tc; sub = ts;
    lit_on = tl_on; lit = tl; lit_ovf = tlo;
    in_valid = 1'b1;
    n = 0;
    took = 1'b0;
    while (!took) begin
      @(negedge clk);
      took = ir[lit_lat];
      @(posedge clk);
      #1;
      n++;
      if (!took && n > 40) begin
        $display("FAIL send_timeout lat=%0d actual in_ready=0 required=1", lit_lat);
        $fatal(1, "handshake stuck");
      end
    end
    in_valid = 1'b0;
    lit_on = 1'b0;
  endtask

  initial begin
    // Reset held with a beat offered; nothing may come out afterwards.
    in_valid = 1'b1; a = 32'd1; b = 32'd2;
    idle(3);
    rst_n = 1'b1;
    in_valid = 1'b0;
    idle(4);

    lit_lat = 2;
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 33'h1_0000_0000, 1'b0);
    idle(3);
    send(32'd5, 32'd7, 1'b0, 1'b1, 1'b1, 33'h0_FFFF_FFFE, 1'b0);
    send(32'd7, 32'd5, 1'b0, 1'b1, 1'b1, 33'h1_0000_0002, 1'b0);
    idle(4);

    // Backpressure on the three-stage instance.
    lit_lat = 3;
    out_ready = 1'b0;
    fork
      begin
        idle(5);
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 6; i++)
      send(W'(i), W'(i), 1'b1, 1'b0, 1'b1, 33'(2 * i + 1), 1'b0);
    idle(6);

    // Reset with two beats in flight.
    send(32'd10, 32'd20, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    send(32'd30, 32'd40, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(6);

    lit_lat = 2;
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 33'h0_8000_0000, 1'b1);
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, 33'h1_7FFF_FFFF, 1'b1);
    send(32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 33'h0_0000_0007, 1'b0);
    idle(4);

    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = (k % 11 == 0) ? 32'hFFFF_FFFF : $urandom;
      b         = (k % 13 == 0) ? 32'h8000_0000 : $urandom;
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      idle(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bk_add_pipe.md
# bk_add_pipe

Parametrised, pipelined Brent-Kung prefix adder/subtractor with valid/ready handshake on both sides. It generalises the fixed 32-bit combinational BK adder to any power-of-two width, with selectable pipeline depth, carry-in, add/subtract mode and backpressure. It sits in the approximate-logic benchmark suite as the sequential reference against which approximated prefix adders are compared cycle-for-cycle.

## Interface
- WIDTH, 32: operand width; power of two, 8..64.
- LATENCY, 2: pipeline depth in cycles, 1..3.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in; ignored when in_sub=1.
- in_sub  in  1  1 = A - B (B inverted, carry-in forced 1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH+1  {carry_out, sum}; for subtract, MSB = 1 means no borrow.
- out_ovf  out  1  signed overflow; present only with BK_ADD_OVF_EN.

## Operation
- Datapath split into three phases: P1 = PG generation (g=a&b', p=a^b', b' = sub ? ~b : b); P2 = BK up-sweep (log2 WIDTH levels); P3 = down-sweep (log2 WIDTH - 1 levels) plus sum XOR and carry-out.
- Register placement: LATENCY=1, output register only; 2, register after P2 plus output; 3, register after P1, after P2, plus output.
- Each stage holds one beat plus a valid bit. A stage loads when it is empty or its contents advance this cycle (per-stage ready, bubbles collapse).
- in_ready = first stage empty or advancing; purely combinational from stage valids and out_ready; no combinational in_valid -> in_ready path.
- Result equals (in_a + b' + cin_eff) mod 2^(WIDTH+1); cin_eff = in_sub ? 1 : in_cin.
- out_sum, out_ovf hold stable while out_valid=1 and out_ready=0.
- No reordering; results leave in acceptance order.

## Timing
- Reset (async assert, synchronous deassert handled upstream): all stage valids 0, all data registers 0; out_valid=0, out_sum=0, out_ovf=0, in_ready=1 from the first cycle after reset release.
- Latency: beat accepted at edge N appears with out_valid=1 after edge N+LATENCY-1... precisely, visible on out_* in the cycle following edge N+LATENCY-1, given no stall.
- Throughput: one beat per cycle with out_ready held high.
- Full: all LATENCY stages valid and out_ready=0 -> in_ready=0.
- Simultaneous: full pipeline with out_ready=1 -> in_ready=1 and new beat accepted the same edge the output is consumed.
- Reset mid-operation: in-flight beats discarded; no partial result emitted.
- Wrap-around: carry out of bit WIDTH-1 lands in out_sum[WIDTH]; no bit beyond WIDTH+1.

## Configuration
- BK_ADD_OVF_EN defined: out_ovf port present, = (a[MSB]==b'[MSB]) & (sum[MSB]!=a[MSB]), pipelined alongside out_sum with identical latency and stall behaviour.
- Undefined: no out_ovf port, no overflow logic or registers.

## Structure
- Package bk_add_pkg: function clog2-based level counts (UP_LEVELS, DOWN_LEVELS), stage-count constant derived from LATENCY, typedef for the PG pair struct {g, p}.
- Sub-module bk_prefix_level: one combinational prefix level parametrised by level index and sweep direction; instantiated via generate in P2 and P3.
- Top holds pipeline registers and handshake logic only.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_sum=0, in_ready=1 after release; no beat emitted.
- WIDTH=32, LATENCY=2: a=0xFFFFFFFF, b=0x1, cin=0 -> out_sum=0x1_00000000 exactly 2 cycles after acceptance.
- Subtract: a=5, b=7, sub=1 -> out_sum=0x0_FFFFFFFE; a=7, b=5 -> 0x1_00000002.
- Backpressure, LATENCY=3: 6 back-to-back beats (a=i, b=i, cin=1), out_ready low 5 cycles -> in_ready falls after 3 beats held, results 1,3,5,7,9,11 in order, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 next cycle, neither beat emitted after release.
- With BK_ADD_OVF_EN: a=0x7FFFFFFF, b=1 -> out_ovf=1; a=0x80000000, b=1, sub=1 -> out_ovf=1; a=3, b=4 -> out_ovf=0; random 10^6 vectors vs. reference model, zero mismatches.
